// File: rtl/config_sequencer_pkg.sv
// Shared definitions for the ZUMA configuration sequencer: state encoding,
// fabric size derivation and the width helper for the word counter.
package config_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam int MAX_TOTAL = 65535;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int total_words(input int stages, input int lutsize);
    return stages << lutsize;
  endfunction

endpackage

// File: rtl/config_stage_decoder.sv
// Combinational stage select: the counter bits above the LUT address pick one
// stage strobe, qualified by the write enable.
module config_stage_decoder #(
  parameter int STAGES  = 16,
  parameter int LUTSIZE = 6,
  parameter int CNT_W   = 11
) (
  input  logic [CNT_W-1:0]  cnt,
  input  logic              wr_en,
  output logic [STAGES-1:0] wren
);

  localparam int SEL_W = CNT_W - LUTSIZE;

  logic [SEL_W-1:0] sel;

  assign sel = cnt[CNT_W-1:LUTSIZE];

  always_comb begin
    wren = '0;
    for (int s = 0; s < STAGES; s++) begin
      wren[s] = wr_en && (sel == SEL_W'(s));
    end
  end

endmodule

// File: rtl/config_sequencer.sv
// Streams a full overlay bitstream into the LUT configuration fabric, one
// registered stage strobe per accepted word, in stage-major address order.
module config_sequencer
  import config_sequencer_pkg::*;
#(
  parameter int WIDTH   = 40,
  parameter int STAGES  = 16,
  parameter int LUTSIZE = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   cfg_data,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic [STAGES-1:0]  wren_out,
  output logic [LUTSIZE-1:0] addr_out,
  output logic [WIDTH-1:0]   data_out,
  output logic [15:0]        progress,
  output logic               busy,
  output logic               done
);

  localparam int TOTAL = total_words(STAGES, LUTSIZE);
  localparam int CNT_W = clog2(TOTAL) + 1;

  generate
    if (TOTAL > MAX_TOTAL) begin : g_size_check
      $error("config_sequencer: STAGES << LUTSIZE exceeds 65535 words");
    end
  endgenerate

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        progress_q, progress_d;

  logic               hs_p0;
  logic [STAGES-1:0]  wren_p0, wren_p1;
  logic [LUTSIZE-1:0] addr_p0, addr_p1;
  logic [WIDTH-1:0]   data_p0, data_p1;

  // Stage 0: handshake, next-state and write formation
  assign hs_p0 = cfg_valid && (state_q == RUN);

  config_stage_decoder #(
    .STAGES  (STAGES),
    .LUTSIZE (LUTSIZE),
    .CNT_W   (CNT_W)
  ) u_stage_decoder (
    .cnt   (cnt_q),
    .wr_en (hs_p0),
    .wren  (wren_p0)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    progress_d = progress_q;
    addr_p0    = addr_p1;
    data_p0    = data_p1;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          cnt_d      = '0;
          progress_d = '0;
        end
      end
      RUN: begin
        if (hs_p0) begin
          cnt_d      = cnt_q + CNT_W'(1);
          progress_d = progress_q + 16'd1;
          addr_p0    = cnt_q[LUTSIZE-1:0];
          data_p0    = cfg_data;
          if (cnt_q == CNT_W'(TOTAL - 1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 1: registered control and write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      progress_q <= '0;
      wren_p1    <= '0;
      addr_p1    <= '0;
      data_p1    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      progress_q <= progress_d;
      wren_p1    <= wren_p0;
      addr_p1    <= addr_p0;
      data_p1    <= data_p0;
    end
  end

  assign cfg_ready = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign progress  = progress_q;
  assign wren_out  = wren_p1;
  assign addr_out  = addr_p1;
  assign data_out  = data_p1;

endmodule

// File: doc/config_sequencer.md
# config_sequencer

Streams a complete ZUMA overlay bitstream into the addressable LUT configuration fabric. It accepts configuration words over a valid/ready handshake and walks a linear address counter across all STAGES × 2^LUTSIZE locations. For each accepted word it issues exactly one registered, one-hot stage write strobe with the matching LUT address and data. It sits between the host/bitstream source and the per-stage configuration write ports, and replaces host-side address generation.

## Interface
- WIDTH, 40, configuration word width (bits per write).
- STAGES, 16, number of configuration stages (one write-enable each).
- LUTSIZE, 6, LUT input count; 2^LUTSIZE words per stage.
- Derived TOTAL = STAGES << LUTSIZE; legal only if TOTAL ≤ 65535 (elaboration error otherwise).

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high; reset is sampled on the clk rising edge.
- start  in  1  begin a configuration pass (sampled in IDLE or DONE only).
- cfg_data  in  WIDTH  configuration word.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  sequencer accepts a word this cycle.
- wren_out  out  STAGES  one-hot stage write strobe, one cycle per word.
- addr_out  out  LUTSIZE  LUT address for the current write.
- data_out  out  WIDTH  data for the current write.
- progress  out  16  number of words accepted in the current pass.
- busy  out  1  pass in progress.
- done  out  1  pass complete.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE: cfg_ready=0 and cfg_valid is ignored. start=1 moves to RUN and clears the counter and progress.
- RUN: cfg_ready=1 and busy=1. A handshake (cfg_valid & cfg_ready) accepts cfg_data at counter value c:
  - the next cycle drives data_out=cfg_data, addr_out=c[LUTSIZE-1:0], and sets only wren_out[c>>LUTSIZE];
  - c and progress increment.
  - start is ignored in RUN.
- The handshake at c = TOTAL-1 moves to DONE. That last write still issues on the following cycle.
- DONE: done=1, busy=0, cfg_ready=0. progress holds TOTAL. start=1 returns to RUN with the counter and progress cleared.
- Order is stage-major: stage 0 addresses 0…2^LUTSIZE-1, then stage 1, and so on.
- Counter width is clog2(TOTAL)+1. It never wraps, because the terminal count exits RUN.
- wren_out is all-zero on every cycle that does not follow a handshake.
- data_out and addr_out hold their last written values between writes.

## Timing
- Reset values: wren_out=0, addr_out=0, data_out=0, progress=0, cfg_ready=0, busy=0, done=0, state=IDLE.
- cfg_ready is a registered state decode, not a function of cfg_valid. It goes high the cycle after start is sampled.
- Write latency: strobe, address and data appear exactly 1 cycle after the handshake cycle, all from registers.
- Back-to-back: with cfg_valid held high, one write per cycle. A full pass takes TOTAL+1 cycles from the first handshake to the last strobe.
- done rises the cycle after the final handshake, coincident with the final wren_out pulse.
- Gaps: cfg_valid low in RUN inserts idle cycles with wren_out=0, and the counter holds.
- Reset mid-pass: the next cycle all outputs take their reset values. A pending write (handshake on the reset cycle) is dropped, with no strobe.
- start and reset high together: reset wins.

## Structure
- Shared header (alongside the math macros):
  - state encoding constants IDLE/RUN/DONE;
  - the TOTAL derivation;
  - clog2 helper for the counter width.
- One sub-module, config_stage_decoder: maps the counter's upper bits to a STAGES-wide one-hot vector, gated by a write-enable input. It is combinational and its output is registered in the parent.
- The parent holds the FSM, counter, progress and output registers.

## Test plan
- Reset then idle: hold cfg_valid=1 with no start for 10 cycles → cfg_ready=0, wren_out=0, progress=0.
- Full pass (defaults): start, then 1024 consecutive words with data = index →
  - word 0: wren_out=16'h0001, addr_out=0;
  - word 64: wren_out=16'h0002, addr_out=0;
  - word 1023: wren_out=16'h8000, addr_out=63;
  - done=1 coincident with the last strobe; progress=1024.
- Throttled input: cfg_valid toggles every other cycle for 130 words → no strobe on gap cycles; addr_out/data_out hold; progress=130.
- Reset mid-pass: reset asserted at word 500 while its handshake occurs → no strobe for word 500; all outputs 0 next cycle. A subsequent start and full pass begins at stage 0, address 0.
- Restart from DONE: after a full pass, assert start → progress clears to 0, cfg_ready=1 next cycle, first strobe is wren_out[0] at addr 0.
- Small config (STAGES=2, LUTSIZE=2): 8 words → strobe sequence stage0×4, stage1×4; done after the 8th; start during RUN ignored.
